// File: rtl/cbus_rr_arbiter_if.sv
// Cache-bus request/response types and the bundle of request/response
// signals that connects the round-robin arbiter to its requesters and to the
// single external cache bus.

package cbus_pkg;

    // Request beat from a CBus master
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
    } cbus_req_t;

    // Response beat from the CBus slave
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 2
);
    import cbus_pkg::*;

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;

    // The arbiter: takes requests and the external response, drives the rest
    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq
    );

    // The surroundings: requesters plus the external bus slave
    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq
    );

endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one external cache bus between several CBus
// masters. A grant is held for a whole burst (until a ready+last beat), after
// which the finishing port drops to lowest priority.

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    cbus_rr_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   winner;
    logic               any_valid;

    // Port index arithmetic modulo the number of requesters
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_INPUTS);
    endfunction

    // Pick the first valid requester scanning from ptr_q upward with wrap
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!any_valid && bus.ireqs[wrap_idx(int'(ptr_q) + k)].valid) begin
                winner    = wrap_idx(int'(ptr_q) + k);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state logic and bus steering for the grant FSM
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        bus.oreq   = '0;
        bus.iresps = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    owner_d = winner;
                end
            end
            BUSY: begin
                bus.oreq                = bus.ireqs[owner_q];
                bus.iresps[owner_q]     = bus.oresp;
                if (bus.oresp.ready && bus.oresp.last) begin
                    state_d = IDLE;
                    ptr_d   = wrap_idx(int'(owner_q) + 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and priority pointer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign owner = owner_q;

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Round-robin arbiter that shares the single external cache bus (`oreq`/`oresp`) between the per-requester CBus masters: the I-side cache/uncached converter and the D-side cache/uncached converter. It replaces the fixed-priority mux at the top of `VTop`. A grant is held for a whole burst, from the first beat until the beat with `last`. Priority then rotates so that no requester can starve another.

## Interface
Parameters:
- `NUM_INPUTS`, default 2: number of requesters. Must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_INPUTS)`: width of the owner index.

Ports:
- `clk`: input, 1 bit. The only clock.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `ireqs`: input, `cbus_req_t [NUM_INPUTS-1:0]`. Per-requester requests. Index 0 is the D-side (`dcreq`); index 1 is the I-side (`icreq`).
- `iresps`: output, `cbus_resp_t [NUM_INPUTS-1:0]`. Per-requester responses.
- `oreq`: output, `cbus_req_t`. Request to the external bus.
- `oresp`: input, `cbus_resp_t`. Response from the external bus.
- `busy`: output, 1 bit. High while a grant is held.
- `owner`: output, `IDX_W` bits. Index of the current grant holder. Valid only when `busy` is high.

## Operation
- FSM has two states:
  - `IDLE`: no grant held.
  - `BUSY`: grant held by `owner_q`.
- Registers:
  - `state_q`
  - `owner_q` (`IDX_W` bits)
  - `ptr_q` (`IDX_W` bits): the highest-priority index for the next arbitration.
- Arbitration, evaluated only in `IDLE`:
  - Candidates are ports with `ireqs[i].valid = 1`.
  - The winner is the first candidate found scanning `ptr_q`, `ptr_q+1`, …, wrapping modulo `NUM_INPUTS`.
  - If any candidate exists: `owner_q ← winner` and `state_q ← BUSY`.
  - If there is no candidate: stay in `IDLE`.
- Outputs in `IDLE`:
  - `oreq = '0`, so `oreq.valid = 0`.
  - Every `iresps[i] = '0`, so no `ready` is seen by any requester.
- Outputs in `BUSY`:
  - `oreq = ireqs[owner_q]`, passed combinationally.
  - `iresps[owner_q] = oresp`, passed combinationally.
  - All other `iresps[j] = '0`.
- Completion: in `BUSY`, a cycle with `oresp.ready && oresp.last` causes:
  - `state_q ← IDLE`
  - `ptr_q ← owner_q + 1`, wrapping to 0 after `NUM_INPUTS-1`. The port that just finished becomes lowest priority.
- Grant lock:
  - The grant does not end for any reason other than completion.
  - If the owner drops `valid` mid-burst, the arbiter stays `BUSY` and forwards `valid = 0`. It still waits for `oresp.last`.
  - Requesters must keep `valid` and request fields stable until `last`. This is a protocol obligation on the requester; it is not checked here.
- Non-owner requests are never forwarded and are not acknowledged. A non-owner keeps `valid` held and waits.
- Top-level remapping: `VTop` connects `ireqs` and `iresps` in place of the existing mux. Address translation is outside this block.

## Timing
- Reset (`resetn = 0`, asynchronous):
  - `state_q = IDLE`, `owner_q = 0`, `ptr_q = 0`.
  - Therefore `oreq = '0`, all `iresps = '0`, `busy = 0`, `owner = 0`.
  - This holds immediately, without waiting for a clock edge.
- Grant latency: `valid` sampled in `IDLE` at edge t gives `oreq.valid = 1` from cycle t+1. Arbitration costs 1 cycle.
- Pass-through: request and response paths are combinational while `BUSY`. Beats proceed at the full external bus rate with no added latency.
- Release:
  - The completion edge returns the FSM to `IDLE`, with one `IDLE` cycle before the next grant.
  - Minimum spacing: the last beat of A at cycle t, then B's `oreq.valid` at t+2.
- Simultaneous events:
  - Requests arriving in the completion cycle are arbitrated in the following `IDLE` cycle, using the updated `ptr_q`.
  - A single-beat transfer, where `ready` and `last` arrive in the first `BUSY` cycle, completes in one `BUSY` cycle.
- Reset mid-burst: returns the block to `IDLE` immediately. Whatever is in flight on the external bus is abandoned; system reset covers the slave as well.
- Outputs `busy` and `owner`:
  - `busy` = (`state_q == BUSY`).
  - `owner` = `owner_q`.

## Test plan
- **Reset:** assert `resetn = 0` mid-`BUSY` → `oreq.valid = 0`, `busy = 0`, `iresps` all 0 in the same cycle. After release, the first arbitration favours port 0.
- **Single requester:** port 1 issues a 4-beat read (`len` = 3), with the slave giving `ready` on each cycle and `last` on beat 4 → `oreq.valid` rises 1 cycle after the request. `iresps[1]` mirrors 4 beats. `iresps[0]` stays 0. `busy` falls after beat 4.
- **Contention and rotation:** ports 0 and 1 both hold `valid` from reset → port 0 is served first and port 1 second (2 cycles after port 0's last). A new port 0 request arriving during port 1's burst is served after it.
- **Starvation freedom:** both ports request continuously for 10 bursts → grants alternate 0,1,0,1,…. Each port receives exactly 5 grants.
- **Grant lock:** the owner drops `valid` after beat 2 of 8, the other port is requesting, and the slave continues to `last` → `owner` is unchanged until `last`. The other port is granted only afterwards.
- **Back-to-back single beat, `NUM_INPUTS` = 3:** ports 0, 1 and 2 all request, each with `ready` + `last` on the first cycle → grants go 0, 1, 2. Each `oreq.valid` pulse is 1 cycle long and separated by 1 `IDLE` cycle.
